// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the IF fetch port, the MA load/store port and
// the shared memory port of mem_port_arbiter.
// master modport: arbiter view (takes requests and mem completion, drives the
// mem command, the read data and the acks). slave modport: the environment
// (requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch requester
  logic              if_re;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rack;
  // memory access (load/store) requester
  logic              ma_re;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [1:0]        ma_len;
  logic [DATA_W-1:0] ma_wdata;
  logic [DATA_W-1:0] ma_rdata;
  logic              ma_rack;
  logic              ma_wack;
  // shared memory port
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_re, if_addr, ma_re, ma_we, ma_addr, ma_len, ma_wdata,
           mem_rdata, mem_ready,
    output if_rdata, if_rack, ma_rdata, ma_rack, ma_wack,
           mem_re, mem_we, mem_addr, mem_len, mem_wdata
  );

  modport slave (
    output if_re, if_addr, ma_re, ma_we, ma_addr, ma_len, ma_wdata,
           mem_rdata, mem_ready,
    input  if_rdata, if_rack, ma_rdata, ma_rack, ma_wack,
           mem_re, mem_we, mem_addr, mem_len, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MA loads/stores,
// one transaction in flight, MA priority with an anti-starvation guarantee for IF.
// Latency: grant registered one edge after the request is seen; ack one edge after mem_ready.
// Backpressure: requests are levels held until their ack; the memory stalls by delaying mem_ready.
// Ports: clk, rst (async, active-high), bus (mem_port_arbiter_if.master), busy (state != IDLE).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IF_RD = 3'd1,
    MA_RD = 3'd2,
    MA_WR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          if_pri;

  // IF overrides MA only once it has watched STARVE_MAX MA grants go by.
  assign if_pri = bus.if_re && (starve_cnt == STARVE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      busy         <= 1'b0;
      bus.mem_re   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_len  <= 2'b00;
      bus.mem_wdata <= '0;
      bus.if_rdata <= '0;
      bus.ma_rdata <= '0;
      bus.if_rack  <= 1'b0;
      bus.ma_rack  <= 1'b0;
      bus.ma_wack  <= 1'b0;
    end else begin
      // acks are single-cycle pulses
      bus.if_rack <= 1'b0;
      bus.ma_rack <= 1'b0;
      bus.ma_wack <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.if_re) starve_cnt <= '0;

          if (bus.ma_we && !if_pri) begin
            // a simultaneous ma_re waits for a later transaction
            state         <= MA_WR;
            busy          <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= bus.ma_addr;
            bus.mem_len   <= bus.ma_len;
            bus.mem_wdata <= bus.ma_wdata;
            if (bus.if_re && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (bus.ma_re && !if_pri) begin
            state        <= MA_RD;
            busy         <= 1'b1;
            bus.mem_re   <= 1'b1;
            bus.mem_addr <= bus.ma_addr;
            bus.mem_len  <= bus.ma_len;
            if (bus.if_re && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (bus.if_re) begin
            state        <= IF_RD;
            busy         <= 1'b1;
            bus.mem_re   <= 1'b1;
            bus.mem_addr <= bus.if_addr;
            bus.mem_len  <= 2'b11;
            starve_cnt   <= '0;
          end
        end

        // Command fields stay frozen here; requester inputs are not looked at.
        IF_RD: begin
          if (bus.mem_ready) begin
            state        <= DONE;
            bus.mem_re   <= 1'b0;
            bus.if_rdata <= bus.mem_rdata;
            bus.if_rack  <= 1'b1;
          end
        end

        MA_RD: begin
          if (bus.mem_ready) begin
            state        <= DONE;
            bus.mem_re   <= 1'b0;
            bus.ma_rdata <= bus.mem_rdata;
            bus.ma_rack  <= 1'b1;
          end
        end

        MA_WR: begin
          if (bus.mem_ready) begin
            state      <= DONE;
            bus.mem_we <= 1'b0;
            bus.ma_wack <= 1'b1;
          end
        end

        // One dead cycle so a request still held during its ack is not re-granted.
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors against mem_port_arbiter with
// hand-computed expectations; the bench plays both requesters and the memory.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the arbiter to raise a strobe; bounded.
  task automatic wait_strobe(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.mem_re || bus.mem_we) seen = 1'b1;
    end
    chk({tag, "_strobe_seen"}, seen, 1'b1);
  endtask

  // Memory answers after dly extra cycles; returns at the ack cycle.
  task automatic serve(input int dly, input logic [31:0] rd);
    repeat (dly) tick();
    bus.mem_rdata = rd;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  function automatic logic [2:0] acks();
    return {bus.if_rack, bus.ma_rack, bus.ma_wack};
  endfunction

  // Strobe exclusivity and single ack per cycle, checked every cycle.
  always @(negedge clk) begin
    if (!rst)
      chk("excl", {62'd0, bus.mem_re & bus.mem_we, $countones(acks()) > 1}, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_if;
    logic       is_if;
    n_vec = 0;
    n_err = 0;

    rst = 1'b1;
    bus.if_re = 0; bus.if_addr = 0;
    bus.ma_re = 0; bus.ma_we = 0; bus.ma_addr = 0; bus.ma_len = 0; bus.ma_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    #1;
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", acks(), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_len", bus.mem_len, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single IF fetch, memory answers one cycle after the strobe.
    bus.if_addr = 32'h100;
    bus.if_re   = 1'b1;
    wait_strobe("if");
    chk("if_mem_re", bus.mem_re, 1);
    chk("if_addr", bus.mem_addr, 32'h100);
    chk("if_len", bus.mem_len, 2'b11);
    chk("if_busy", busy, 1);
    bus.if_addr = 32'h200;
    tick();
    chk("if_addr_frozen", bus.mem_addr, 32'h100);
    serve(0, 32'hDEADBEEF);
    chk("if_ack", acks(), 3'b100);
    chk("if_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("if_strobe_drop", bus.mem_re, 0);
    chk("if_busy_done", busy, 1);
    tick();
    // if_re still held through DONE: must not have been re-granted
    chk("done_no_regrant", bus.mem_re, 0);
    chk("if_busy_idle", busy, 0);
    chk("if_ack_pulse", acks(), 0);
    bus.if_re = 1'b0;
    tick();
    chk("if_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

    // IF and MA together: MA read first, then IF.
    bus.if_addr = 32'h300; bus.if_re = 1'b1;
    bus.ma_addr = 32'h44;  bus.ma_len = 2'b01; bus.ma_re = 1'b1;
    wait_strobe("both1");
    chk("both1_addr", bus.mem_addr, 32'h44);
    chk("both1_len", bus.mem_len, 2'b01);
    serve(0, 32'h0000_8001);
    chk("both1_ack", acks(), 3'b010);
    chk("both1_rdata", bus.ma_rdata, 32'h0000_8001);
    bus.ma_re = 1'b0;
    tick();
    chk("both_done_idle", bus.mem_re, 0);
    wait_strobe("both2");
    chk("both2_addr", bus.mem_addr, 32'h300);
    serve(2, 32'hCAFE_0001);
    chk("both2_ack", acks(), 3'b100);
    chk("both2_rdata", bus.if_rdata, 32'hCAFE_0001);
    chk("ma_rdata_hold", bus.ma_rdata, 32'h0000_8001);
    bus.if_re = 1'b0;
    tick(); tick();

    // Starvation: MA held continuously, IF waits -> MA, MA, IF, MA, MA.
    exp_if = 5'b00100;
    bus.if_addr = 32'h500; bus.if_re = 1'b1;
    bus.ma_addr = 32'h60;  bus.ma_len = 2'b00; bus.ma_re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_strobe($sformatf("starve%0d", i));
      is_if = (bus.mem_addr == 32'h500);
      chk($sformatf("starve%0d_who", i), is_if, exp_if[i]);
      chk($sformatf("starve%0d_len", i), bus.mem_len, exp_if[i] ? 2'b11 : 2'b00);
      serve(0, 32'h1000 + i);
      chk($sformatf("starve%0d_ack", i), acks(), exp_if[i] ? 3'b100 : 3'b010);
      if (exp_if[i]) bus.if_re = 1'b0;
      if (i == 4) bus.ma_re = 1'b0;
    end
    tick(); tick();
    chk("starve_end_idle", busy, 0);

    // Write and read together: write first, then read.
    bus.ma_addr = 32'h40; bus.ma_wdata = 32'h55; bus.ma_len = 2'b11;
    bus.ma_we = 1'b1; bus.ma_re = 1'b1;
    wait_strobe("wr");
    chk("wr_we", bus.mem_we, 1);
    chk("wr_re", bus.mem_re, 0);
    chk("wr_wdata", bus.mem_wdata, 32'h55);
    chk("wr_addr", bus.mem_addr, 32'h40);
    serve(1, 32'h0);
    chk("wr_ack", acks(), 3'b001);
    bus.ma_we = 1'b0;
    wait_strobe("rd");
    chk("rd_re", bus.mem_re, 1);
    chk("rd_addr", bus.mem_addr, 32'h40);
    serve(0, 32'h0000_00A5);
    chk("rd_ack", acks(), 3'b010);
    chk("rd_rdata", bus.ma_rdata, 32'h0000_00A5);
    bus.ma_re = 1'b0;
    tick(); tick();

    // Request dropped mid-transaction still completes with an ack.
    bus.ma_addr = 32'h70; bus.ma_len = 2'b00; bus.ma_re = 1'b1;
    wait_strobe("drop");
    bus.ma_re = 1'b0;
    tick();
    chk("drop_still_re", bus.mem_re, 1);
    serve(0, 32'h0000_0011);
    chk("drop_ack", acks(), 3'b010);
    tick(); tick();

    // Reset mid-write aborts immediately; late mem_ready ignored.
    bus.ma_addr = 32'h80; bus.ma_wdata = 32'h77; bus.ma_we = 1'b1;
    wait_strobe("abort");
    chk("abort_we", bus.mem_we, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_we_drop", bus.mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", bus.mem_addr, 0);
    chk("abort_wdata", bus.mem_wdata, 0);
    chk("abort_if_rdata", bus.if_rdata, 0);
    chk("abort_ma_rdata", bus.ma_rdata, 0);
    bus.ma_we = 1'b0;
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("abort_no_ack", acks(), 0);
    chk("abort_idle", busy, 0);
    tick();
    chk("abort_no_ack2", acks(), 0);

    // Spurious mem_ready in IDLE.
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("spur_ack", acks(), 0);
    chk("spur_busy", busy, 0);
    chk("spur_strobe", {bus.mem_re, bus.mem_we}, 0);
    tick();
    chk("spur_busy2", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_MAX, default 2, consecutive MA grants allowed while IF waits.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_re  in  1  IF fetch request, level, held until if_rack.
REQ-007 if_addr  in  ADDR_W  IF fetch address.
REQ-008 if_rdata  out  DATA_W  fetched word, valid while if_rack=1.
REQ-009 if_rack  out  1  IF read done, one-cycle pulse.
REQ-010 ma_re / ma_we  in  1 each  MA read / write request, level, held until the matching ack.
REQ-011 ma_addr  in  ADDR_W  MA address; ma_len  in  2  size (00 byte, 01 half, 11 word).
REQ-012 ma_wdata  in  DATA_W  MA store data.
REQ-013 ma_rdata  out  DATA_W  raw load data, valid while ma_rack=1; ma_rack / ma_wack  out  1  one-cycle pulses.
REQ-014 mem_re / mem_we  out  1 each  shared port strobes, level, held until mem_ready.
REQ-015 mem_addr  out  ADDR_W; mem_len  out  2; mem_wdata  out  DATA_W: port command fields.
REQ-016 mem_rdata  in  DATA_W  port read data, sampled when mem_ready=1.
REQ-017 mem_ready  in  1  port completion, one-cycle pulse.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, IF_RD, MA_RD, MA_WR, DONE; one transaction in flight.
REQ-020 IDLE priority: ma_we > ma_re > if_re, except if_re wins when starve_cnt == STARVE_MAX.
REQ-021 starve_cnt: +1 per MA grant while if_re=1, saturates at STARVE_MAX; cleared on IF grant or when if_re=0 in IDLE.
REQ-022 Grant registered: request seen in IDLE at edge N -> state, strobe, mem_addr, mem_len, mem_wdata valid after edge N.
REQ-023 IF grant: mem_re=1, mem_addr=if_addr, mem_len=11; MA read: mem_re=1, mem_len=ma_len; MA write: mem_we=1, mem_wdata=ma_wdata.
REQ-024 Command fields frozen from grant until mem_ready; requester input changes during transaction ignored.
REQ-025 mem_ready=1 in IF_RD/MA_RD/MA_WR: next edge drops strobe, captures mem_rdata into if_rdata or ma_rdata (reads only), pulses matching ack, enters DONE.
REQ-026 DONE lasts exactly one cycle, no grant made, then IDLE; prevents re-grant of a request still held during its ack cycle.
REQ-027 Minimum latency: request at edge N, mem_ready same cycle as strobe -> ack high after edge N+2; next grant earliest edge N+4.
REQ-028 ma_re and ma_we both high: write serviced first, read in a later transaction.
REQ-029 Requester drops request mid-transaction: transaction completes, ack still pulsed.
REQ-030 mem_ready in IDLE or DONE ignored; no ack, no state change.
REQ-031 mem_re and mem_we never both 1; at most one ack output high per cycle.
REQ-032 if_rdata/ma_rdata hold last captured value until next capture; no sign extension (MA stage's job).

Reset
REQ-033 rst=1: state IDLE, starve_cnt 0, all strobes, acks, busy 0, mem_addr/mem_wdata/if_rdata/ma_rdata 0, mem_len 00, immediately regardless of clk.
REQ-034 rst mid-transaction aborts it; no ack issued for aborted request; mem_ready arriving after release ignored.

Verification
REQ-035 if_re=1, if_addr=0x100, mem_ready one cycle after mem_re, mem_rdata=0xDEADBEEF -> mem_len=11, if_rack pulse with if_rdata=0xDEADBEEF, busy back to 0 one cycle later.
REQ-036 if_re and ma_re high in same IDLE cycle -> MA granted first, ma_rack, DONE, then IF granted.
REQ-037 ma_re held continuously with if_re, STARVE_MAX=2 -> grant order MA, MA, IF, MA, MA.
REQ-038 ma_re and ma_we both high, ma_addr=0x40, ma_wdata=0x55 -> mem_we with mem_wdata=0x55 first, ma_wack; then mem_re, ma_rack.
REQ-039 rst pulsed while MA_WR waiting on mem_ready -> mem_we=0 at once, no ma_wack; later mem_ready pulse produces no ack.
REQ-040 Spurious mem_ready in IDLE -> no ack, busy stays 0, state IDLE.
